// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transfer arbiter: FSM state encoding,
// the native SPI word width and modular index arithmetic.
package spi_arb_pkg;

  localparam int SPI_WORD_W = 12;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LAUNCH,
    ARB_XFER,
    ARB_DONE
  } arb_state_t;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int rot_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational rotate-priority picker: returns the first asserted request
// found scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] pick
);

  localparam int ID_W = $clog2(NUM_REQ);

  // NOTE: blocking (=) in combinational logic so later loop iterations see the
  // updates of earlier ones; non-blocking (<=) is reserved for clocked state.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[rot_idx(int'(rr_ptr), i, NUM_REQ)]) begin
        valid = 1'b1;
        pick  = ID_W'(rot_idx(int'(rr_ptr), i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters; launches
// a transfer via spi_newd/spi_din, follows master cs, returns a 1-cycle ack.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SPI_WORD_W,
  parameter int TIMEOUT = 4095
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        ack_err,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        spi_newd,
  output logic [DATA_W-1:0]           spi_din,
  input  logic                        spi_cs
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   spi_din_q, spi_din_d;
  logic                spi_newd_q, spi_newd_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                ack_err_q, ack_err_d;
  logic                cs_q, cs_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick;
  logic                cs_fall, cs_rise, tmo_hit;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .pick   (pick)
  );

  assign cs_fall = cs_q & ~spi_cs;
  assign cs_rise = ~cs_q & spi_cs;
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT));

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing assignment in always_comb would infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    spi_din_d  = spi_din_q;
    spi_newd_d = spi_newd_q;
    tmo_cnt_d  = tmo_cnt_q;
    ack_d      = '0;
    ack_err_d  = 1'b0;
    cs_d       = spi_cs;

    // phase timer saturates so a stuck master cannot wrap it back below TIMEOUT
    if ((state_q == ARB_LAUNCH || state_q == ARB_XFER) && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_LAUNCH;
          grant_id_d = pick;
          spi_din_d  = req_data[int'(pick)*DATA_W +: DATA_W];
          spi_newd_d = 1'b1;
          tmo_cnt_d  = '0;
        end
      end
      ARB_LAUNCH: begin
        if (cs_fall) begin
          state_d    = ARB_XFER;
          spi_newd_d = 1'b0;
          tmo_cnt_d  = '0;
        end else if (tmo_hit) begin
          state_d           = ARB_DONE;
          spi_newd_d        = 1'b0;
          ack_d[grant_id_q] = 1'b1;
          ack_err_d         = 1'b1;
        end
      end
      ARB_XFER: begin
        if (cs_rise) begin
          state_d           = ARB_DONE;
          ack_d[grant_id_q] = 1'b1;
        end else if (tmo_hit) begin
          state_d           = ARB_DONE;
          ack_d[grant_id_q] = 1'b1;
          ack_err_d         = 1'b1;
        end
      end
      ARB_DONE: begin
        // ack is registered on entry, so it is high for exactly this state
        state_d  = ARB_IDLE;
        rr_ptr_d = ID_W'(rot_idx(int'(grant_id_q), 1, NUM_REQ));
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      spi_din_q  <= '0;
      spi_newd_q <= 1'b0;
      tmo_cnt_q  <= '0;
      ack_q      <= '0;
      ack_err_q  <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      spi_din_q  <= spi_din_d;
      spi_newd_q <= spi_newd_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ack_q      <= ack_d;
      ack_err_q  <= ack_err_d;
      cs_q       <= cs_d;
    end
  end

  assign ack      = ack_q;
  assign ack_err  = ack_err_q;
  assign busy     = (state_q != ARB_IDLE);
  assign grant_id = grant_id_q;
  assign spi_newd = spi_newd_q;
  assign spi_din  = spi_din_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: a vector table of grants plus
// hand-written sequences for rotation, timeouts, reset and dropped requests.
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 12;
  localparam int TIMEOUT  = 4095;
  localparam int LEAD     = 2;            // master: clks from newd seen to cs low
  localparam int HOLD     = DATA_W * 20;  // master: cs low time, sclk = clk/20
  localparam int LAT_OK   = HOLD + 2;     // grant edge to ack for a good transfer
  localparam int M_NORMAL = 0;
  localparam int M_STUB   = 1;
  localparam int M_HANG   = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NUM_REQ-1:0]         req = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]         ack;
  logic                       ack_err;
  logic                       busy;
  logic [1:0]                 grant_id;
  logic                       spi_newd;
  logic [DATA_W-1:0]          spi_din;
  logic                       spi_cs = 1'b1;

  int                         m_mode = M_NORMAL;
  int                         m_cnt  = 0;
  logic [DATA_W-1:0]          m_word = '0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [1:0]                gid;
    logic [DATA_W-1:0]         din;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .ack_err  (ack_err),
    .busy     (busy),
    .grant_id (grant_id),
    .spi_newd (spi_newd),
    .spi_din  (spi_din),
    .spi_cs   (spi_cs)
  );

  // Behavioural SPI master: latches din and drops cs LEAD clks after newd,
  // keeps cs low for HOLD clks. STUB never drops cs; HANG never raises it.
  always @(negedge clk) begin
    if (rst || m_mode == M_STUB) begin
      spi_cs = 1'b1;
      m_cnt  = 0;
    end else if (spi_cs) begin
      if (spi_newd) begin
        if (m_cnt == LEAD - 1) begin
          spi_cs = 1'b0;
          m_word = spi_din;
          m_cnt  = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0;
      end
    end else if (m_mode == M_NORMAL) begin
      if (m_cnt == HOLD - 1) begin
        spi_cs = 1'b1;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, ".ack"},      ack,      0);
    check({name, ".ack_err"},  ack_err,  0);
    check({name, ".busy"},     busy,     0);
    check({name, ".grant_id"}, grant_id, 0);
    check({name, ".spi_newd"}, spi_newd, 0);
    check({name, ".spi_din"},  spi_din,  0);
  endtask

  // Waits for any ack bit, bounded; cyc counts posedges waited.
  task automatic wait_ack(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (ack == '0 && cyc < 3 * TIMEOUT);
    check({name, ".ack_seen"}, |ack, 1);
  endtask

  task automatic do_xact(input string name, input logic [NUM_REQ-1:0] r,
                         input logic [NUM_REQ*DATA_W-1:0] d, input logic [1:0] eg,
                         input logic [DATA_W-1:0] ed, input int exp_lat,
                         input bit exp_err, input bit chk_word);
    int cyc;
    @(negedge clk);
    req      = r;
    req_data = d;
    @(posedge clk); #1;
    check({name, ".newd"},     spi_newd, 1);
    check({name, ".busy"},     busy,     1);
    check({name, ".grant_id"}, grant_id, eg);
    check({name, ".spi_din"},  spi_din,  ed);
    wait_ack(name, cyc);
    check({name, ".latency"},  cyc,      exp_lat);
    check({name, ".ack"},      ack,      4'b0001 << eg);
    check({name, ".ack_err"},  ack_err,  exp_err);
    check({name, ".newd_off"}, spi_newd, 0);
    if (chk_word) check({name, ".shifted"}, m_word, ed);
    req = '0;
    @(posedge clk); #1;
    check({name, ".ack_once"}, ack,  0);
    check({name, ".idle"},     busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [1:0] eg;

    vecs[0]  = '{4'b0100, {12'h3C0, 12'hA5C, 12'h1C0, 12'h0C0}, 2'd2, 12'hA5C};
    vecs[1]  = '{4'b1111, {12'h3C1, 12'h2C1, 12'h1C1, 12'h0C1}, 2'd3, 12'h3C1};
    vecs[2]  = '{4'b1111, {12'h3C2, 12'h2C2, 12'h1C2, 12'h0C2}, 2'd0, 12'h0C2};
    vecs[3]  = '{4'b0101, {12'h3C3, 12'h2C3, 12'h1C3, 12'h0C3}, 2'd2, 12'h2C3};
    vecs[4]  = '{4'b0011, {12'h3C4, 12'h2C4, 12'h1C4, 12'h0C4}, 2'd0, 12'h0C4};
    vecs[5]  = '{4'b0011, {12'h3C5, 12'h2C5, 12'h1C5, 12'h0C5}, 2'd1, 12'h1C5};
    vecs[6]  = '{4'b1001, {12'h3C6, 12'h2C6, 12'h1C6, 12'h0C6}, 2'd3, 12'h3C6};
    vecs[7]  = '{4'b1110, {12'h3C7, 12'h2C7, 12'h1C7, 12'h0C7}, 2'd1, 12'h1C7};
    vecs[8]  = '{4'b0001, {12'h3C8, 12'h2C8, 12'h1C8, 12'h0C8}, 2'd0, 12'h0C8};
    vecs[9]  = '{4'b1000, {12'h3C9, 12'h2C9, 12'h1C9, 12'h0C9}, 2'd3, 12'h3C9};
    vecs[10] = '{4'b0001, {12'h000, 12'h000, 12'h000, 12'hFFF}, 2'd0, 12'hFFF};

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset0");
    rst = 1'b0;

    // Table: grant order follows rr_ptr, which starts at 0 and moves past each grantee
    for (int i = 0; i < 11; i++) begin
      do_xact($sformatf("vec%0d", i), vecs[i].req, vecs[i].data, vecs[i].gid,
              vecs[i].din, LAT_OK, 1'b0, 1'b1);
    end

    // All four requesting from reset: strict rotation 0,1,2,3,0
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("reset1");
    rst = 1'b0;
    @(negedge clk);
    req      = 4'b1111;
    req_data = {12'h4D3, 12'h4D2, 12'h4D1, 12'h4D0};
    for (int k = 0; k < 5; k++) begin
      eg = 2'(k % 4);
      wait_ack($sformatf("rot%0d", k), cyc);
      check($sformatf("rot%0d.ack", k),  ack,    4'b0001 << eg);
      check($sformatf("rot%0d.word", k), m_word, 12'h4D0 | 12'(eg));
      if (k == 4) req = '0;
      @(posedge clk); #1;
      check($sformatf("rot%0d.ack_once", k), ack,  0);
      check($sformatf("rot%0d.gap", k),      busy, 0);
      if (k < 4) begin
        @(posedge clk); #1;
        check($sformatf("rot%0d.regrant", k), {busy, spi_newd}, 2'b11);
      end
    end

    // Last grant was 0, so with req[0] re-raised alongside req[1], 1 wins
    do_xact("rr_after0", 4'b0011, {12'h533, 12'h522, 12'h511, 12'h500}, 2'd1, 12'h511,
            LAT_OK, 1'b0, 1'b1);

    // Master never drops cs: LAUNCH times out TIMEOUT+1 clks after grant
    m_mode = M_STUB;
    do_xact("tmo_launch", 4'b0100, {12'h633, 12'h622, 12'h611, 12'h600}, 2'd2, 12'h622,
            TIMEOUT + 1, 1'b1, 1'b0);

    // Master never raises cs: XFER times out TIMEOUT+1 clks after cs falls
    m_mode = M_HANG;
    do_xact("tmo_xfer", 4'b0001, {12'h733, 12'h722, 12'h711, 12'h700}, 2'd0, 12'h700,
            TIMEOUT + 3, 1'b1, 1'b1);
    m_mode = M_STUB;
    repeat (2) @(posedge clk);
    #1;
    m_mode = M_NORMAL;
    check("tmo_xfer.cs_release_idle", busy, 0);

    // req[3] dropped mid-transfer: still acked once, never regranted
    @(negedge clk);
    req      = 4'b1000;
    req_data = {12'h8D3, 12'h822, 12'h811, 12'h800};
    @(posedge clk); #1;
    check("drop.grant_id", grant_id, 3);
    cyc = 0;
    while (spi_newd && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drop.in_xfer", {busy, spi_newd}, 2'b10);
    req = '0;
    wait_ack("drop", cyc);
    check("drop.ack",     ack,     4'b1000);
    check("drop.ack_err", ack_err, 0);
    check("drop.shifted", m_word,  12'h8D3);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("drop.quiet%0d", k), {ack, busy}, 5'b00000);
    end

    // Reset mid-XFER: outputs return to reset values, no ack, clean restart
    @(negedge clk);
    req      = 4'b0100;
    req_data = {12'h933, 12'h922, 12'h911, 12'h900};
    @(posedge clk); #1;
    check("rstmid.grant_id", grant_id, 2);
    cyc = 0;
    while (spi_newd && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (10) @(posedge clk);
    #1;
    check("rstmid.in_xfer", {busy, spi_newd, spi_cs}, 3'b100);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rstmid");
    rst = 1'b0;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid.quiet%0d", k), {ack, busy}, 5'b00000);
    end
    do_xact("rstmid_restart", 4'b1010, {12'hA33, 12'hA22, 12'hA11, 12'hA00}, 2'd1, 12'hA11,
            LAT_OK, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
